// File: rtl/prog_fsm_pkg.sv
// Shared definitions for the table-programmable Moore FSM: size limits,
// config-select encoding and the state-index width helper.
package prog_fsm_pkg;

    localparam int MAX_STATES = 16;
    localparam int MAX_X_W    = 3;

    // Which table a config write targets.
    typedef enum logic {
        CFG_TRANS = 1'b0,
        CFG_OUT   = 1'b1
    } cfg_sel_e;

    // Width of a state index: max(1, clog2(n)).
    function automatic int state_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prog_fsm_table.sv
// Transition and output tables of the programmable Moore FSM.
// Register arrays with synchronous write, synchronous clear on reset and
// range-checked writes; combinational next-state / output lookup so the FSM
// sees a zero-latency table. A write at edge N is seen by the lookup from N+1.
module prog_fsm_table
    import prog_fsm_pkg::*;
#(
    parameter int NUM_STATES  = 8,
    parameter int X_W         = 1,
    parameter int Y_W         = 1,
    parameter int RESET_STATE = 0,
    parameter int SW          = 3,
    parameter int DW          = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           wr_en,
    input  cfg_sel_e       cfg_sel,
    input  logic [SW-1:0]  cfg_state,
    input  logic [X_W-1:0] cfg_x,
    input  logic [DW-1:0]  cfg_data,
    input  logic [SW-1:0]  current_state,
    input  logic [X_W-1:0] x,
    output logic [SW-1:0]  next_state,
    output logic [Y_W-1:0] y,
    output logic           wr_illegal
);

    localparam int NX = 1 << X_W;
    localparam logic [SW-1:0] RESET_IDX = SW'(RESET_STATE);

    logic [SW-1:0]         trans_reg [NUM_STATES][NX];
    logic [Y_W-1:0]        out_reg   [NUM_STATES];
    logic                  state_oob;
    logic                  data_oob;
    logic                  wr_ok;
    logic [NUM_STATES-1:0] row_hit;

    // A row index outside the machine, or a transition target outside it,
    // would let current_state escape the legal range, so such writes are dropped.
    assign state_oob  = 32'(cfg_state) >= NUM_STATES;
    assign data_oob   = (cfg_sel == CFG_TRANS) && (32'(cfg_data) >= NUM_STATES);
    assign wr_illegal = wr_en && (state_oob || data_oob);
    assign wr_ok      = wr_en && !state_oob && !data_oob;

    // One-hot row decode of a legal write.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_STATES; gi++) begin : g_row_hit
            assign row_hit[gi] = wr_ok && (cfg_state == SW'(gi));
        end
    endgenerate

    // Table storage: wipe to RESET_STATE / zero outputs on reset, else write the addressed entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_STATES; r++) begin
                out_reg[r] <= '0;
                for (int c = 0; c < NX; c++) begin
                    trans_reg[r][c] <= RESET_IDX;
                end
            end
        end else begin
            for (int r = 0; r < NUM_STATES; r++) begin
                if (row_hit[r]) begin
                    if (cfg_sel == CFG_TRANS) begin
                        trans_reg[r][cfg_x] <= cfg_data[SW-1:0];
                    end else begin
                        out_reg[r] <= cfg_data[Y_W-1:0];
                    end
                end
            end
        end
    end

    // Lookup; an out-of-range current state falls back to RESET_STATE.
    always_comb begin
        next_state = RESET_IDX;
        y          = '0;
        if (32'(current_state) < NUM_STATES) begin
            next_state = trans_reg[current_state][x];
            y          = out_reg[current_state];
        end
    end

endmodule

// File: rtl/prog_moore_fsm.sv
// Table-programmable Moore FSM top: state register with run gating, config
// write interlock (writes only while stopped), sticky cfg_err and an optional
// self-loop watchdog.
// Optional feature macro: PROG_FSM_STUCK_EN enables the stuck watchdog;
// without it stuck is tied low and no counter exists.
module prog_moore_fsm
    import prog_fsm_pkg::*;
#(
    parameter int NUM_STATES   = 8,
    parameter int X_W          = 1,
    parameter int Y_W          = 1,
    parameter int RESET_STATE  = 0,
    parameter int STUCK_CYCLES = 16,
    localparam int SW = state_w(NUM_STATES),
    localparam int DW = (SW > Y_W) ? SW : Y_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           run,
    input  logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [SW-1:0]  current_state,
    output logic [SW-1:0]  next_state,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic           cfg_sel,
    input  logic [SW-1:0]  cfg_state,
    input  logic [X_W-1:0] cfg_x,
    input  logic [DW-1:0]  cfg_data,
    output logic           cfg_err,
    output logic           stuck
);

    // Elaboration-time guard on the parameter ranges the tables are built for.
    generate
        if (NUM_STATES < 2 || NUM_STATES > MAX_STATES || X_W < 1 || X_W > MAX_X_W ||
            RESET_STATE < 0 || RESET_STATE >= NUM_STATES || STUCK_CYCLES < 1) begin : g_param_err
            $error("prog_moore_fsm: parameter out of range");
        end
    endgenerate

    logic [SW-1:0] current_state_reg;
    logic          cfg_err_reg;
    logic          wr_en;
    logic          wr_illegal;
    logic [SW-1:0] lookup_state;

    // Tables may only change while the machine is stopped.
    assign cfg_ready     = ~run;
    assign wr_en         = cfg_valid && cfg_ready;
    assign current_state = current_state_reg;
    assign next_state    = lookup_state;
    assign cfg_err       = cfg_err_reg;

    prog_fsm_table #(
        .NUM_STATES  (NUM_STATES),
        .X_W         (X_W),
        .Y_W         (Y_W),
        .RESET_STATE (RESET_STATE),
        .SW          (SW),
        .DW          (DW)
    ) u_table (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .cfg_sel       (cfg_sel_e'(cfg_sel)),
        .cfg_state     (cfg_state),
        .cfg_x         (cfg_x),
        .cfg_data      (cfg_data),
        .current_state (current_state_reg),
        .x             (x),
        .next_state    (lookup_state),
        .y             (y),
        .wr_illegal    (wr_illegal)
    );

    // State register: advance only while running, reset has priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            current_state_reg <= SW'(RESET_STATE);
        end else if (run) begin
            current_state_reg <= lookup_state;
        end
    end

    // Sticky illegal-write flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_err_reg <= 1'b0;
        end else if (wr_illegal) begin
            cfg_err_reg <= 1'b1;
        end
    end

`ifdef PROG_FSM_STUCK_EN
    localparam int CW = $clog2(STUCK_CYCLES + 1);
    localparam logic [CW-1:0] STUCK_MAX = CW'(STUCK_CYCLES);

    logic [CW-1:0] stuck_cnt_reg;

    // Count consecutive running self-loop edges, saturating at the threshold.
    always_ff @(posedge clk) begin
        if (reset || !run || (lookup_state != current_state_reg)) begin
            stuck_cnt_reg <= '0;
        end else if (stuck_cnt_reg != STUCK_MAX) begin
            stuck_cnt_reg <= stuck_cnt_reg + 1'b1;
        end
    end

    assign stuck = (stuck_cnt_reg == STUCK_MAX);
`else
    assign stuck = 1'b0;
`endif

endmodule

// File: tb/tb_prog_moore_fsm.sv
// Self-checking bench for prog_moore_fsm: directed scenarios with literal
// expectations followed by randomized traffic, all checked every cycle
// against a table-level behavioural model.
module tb_prog_moore_fsm;

    localparam int NS  = 12;
    localparam int XW  = 1;
    localparam int YW  = 2;
    localparam int RST = 0;
    localparam int STK = 16;
    localparam int SW  = 4;
    localparam int DW  = 4;
`ifdef PROG_FSM_STUCK_EN
    localparam bit STUCK_EN = 1'b1;
`else
    localparam bit STUCK_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset, run, cfg_valid, cfg_sel;
    logic [XW-1:0]  x, cfg_x;
    logic [SW-1:0]  cfg_state;
    logic [DW-1:0]  cfg_data;
    logic [YW-1:0]  y;
    logic [SW-1:0]  current_state, next_state;
    logic           cfg_ready, cfg_err, stuck;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: plain tables indexed by state and input.
    int m_trans [16][2];
    int m_out   [16];
    int m_state;
    bit m_err;
    int m_cnt;
    bit chk_en = 1'b0;

    int tt0 [8] = '{5, 3, 5, 3, 3, 5, 6, 6};
    int tt1 [8] = '{1, 2, 4, 2, 2, 1, 7, 0};

    prog_moore_fsm #(
        .NUM_STATES   (NS),
        .X_W          (XW),
        .Y_W          (YW),
        .RESET_STATE  (RST),
        .STUCK_CYCLES (STK)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .x             (x),
        .y             (y),
        .current_state (current_state),
        .next_state    (next_state),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_sel       (cfg_sel),
        .cfg_state     (cfg_state),
        .cfg_x         (cfg_x),
        .cfg_data      (cfg_data),
        .cfg_err       (cfg_err),
        .stuck         (stuck)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 16; s++) begin
            m_out[s] = 0;
            for (int c = 0; c < 2; c++) m_trans[s][c] = RST;
        end
        m_state = RST;
        m_err   = 1'b0;
        m_cnt   = 0;
    endtask

    // Apply the rules of one clock edge to the model using the inputs held across it.
    task automatic model_step();
        int ns;
        if (reset) begin
            model_reset();
        end else begin
            ns = m_trans[m_state][int'(x)];
            if (cfg_valid && !run) begin
                if (int'(cfg_state) >= NS || (!cfg_sel && int'(cfg_data) >= NS))
                    m_err = 1'b1;
                else if (!cfg_sel)
                    m_trans[int'(cfg_state)][int'(cfg_x)] = int'(cfg_data);
                else
                    m_out[int'(cfg_state)] = int'(cfg_data) % (1 << YW);
            end
            if (run) begin
                if (ns == m_state) m_cnt = (m_cnt < STK) ? m_cnt + 1 : STK;
                else               m_cnt = 0;
                m_state = ns;
            end else begin
                m_cnt = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wr(input bit sel, input int st, input int xx, input int d);
        cfg_valid = 1'b1;
        cfg_sel   = sel;
        cfg_state = SW'(st);
        cfg_x     = XW'(xx);
        cfg_data  = DW'(d);
        $display("cfg write sel=%0d state=%0d x=%0d data=%0d", sel, st, xx, d);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic program_table();
        for (int s = 0; s < 8; s++) begin
            wr(1'b0, s, 0, tt0[s]);
            wr(1'b0, s, 1, tt1[s]);
        end
        wr(1'b1, 0, 0, 1);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("current_state", int'(current_state), m_state);
            check("next_state", int'(next_state), m_trans[m_state][int'(x)]);
            check("y", int'(y), m_out[m_state]);
            check("cfg_ready", int'(cfg_ready), int'(!run));
            check("cfg_err", int'(cfg_err), int'(m_err));
            check("stuck", int'(stuck), int'(STUCK_EN && m_cnt >= STK));
        end
    end

    initial begin
        int exp_path [5] = '{1, 2, 4, 3, 3};
        int xs       [5] = '{1, 1, 1, 0, 0};

        model_reset();
        reset = 1'b1; run = 1'b0; x = '0;
        cfg_valid = 1'b0; cfg_sel = 1'b0; cfg_state = '0; cfg_x = '0; cfg_data = '0;

        // Reset for two cycles.
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_state", int'(current_state), 0);
        check("rst_y", int'(y), 0);
        check("rst_cfg_err", int'(cfg_err), 0);
        x = 1'b0; #1;
        check("rst_next_x0", int'(next_state), 0);
        x = 1'b1; #1;
        check("rst_next_x1", int'(next_state), 0);

        // Program the 8-state machine and run it.
        program_table();
        run = 1'b1; x = 1'b1; #1;
        check("run_state_c0", int'(current_state), 0);
        check("run_y_c0", int'(y), 1);
        for (int i = 0; i < 5; i++) begin
            x = XW'(xs[i]);
            tick();
            $display("run step %0d x=%0d state=%0d y=%0d", i, xs[i], current_state, y);
            check("run_state", int'(current_state), exp_path[i]);
            check("run_y", int'(y), 0);
        end
        run = 1'b0;

        // Illegal writes: bad row, then bad target.
        wr(1'b0, 13, 0, 2);
        check("illegal_row_err", int'(cfg_err), 1);
        x = 1'b0; #1;
        check("illegal_row_table", int'(next_state), 3);
        wr(1'b0, 3, 0, 12);
        check("illegal_data_err", int'(cfg_err), 1);
        check("illegal_data_table", int'(next_state), 3);

        // Write held while running must wait for run to drop.
        run = 1'b1; x = 1'b0;
        cfg_valid = 1'b1; cfg_sel = 1'b0; cfg_state = 4'd3; cfg_x = 1'b0; cfg_data = 4'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("interlock_state", int'(current_state), 3);
            check("interlock_next", int'(next_state), 3);
        end
        run = 1'b0; #1;
        check("interlock_pre", int'(next_state), 3);
        tick();
        cfg_valid = 1'b0;
        check("interlock_landed", int'(next_state), 7);
        check("interlock_hold", int'(current_state), 3);
        run = 1'b1;
        tick();
        check("interlock_used", int'(current_state), 7);
        run = 1'b0;

        // Same-cycle visibility of a rewritten entry.
        wr(1'b0, 7, 1, 5);
        x = 1'b1; #1;
        check("vis_before", int'(next_state), 5);
        cfg_valid = 1'b1; cfg_sel = 1'b0; cfg_state = 4'd7; cfg_x = 1'b1; cfg_data = 4'd6; #1;
        check("vis_write_cycle", int'(next_state), 5);
        tick();
        cfg_valid = 1'b0;
        check("vis_after", int'(next_state), 6);
        run = 1'b1;
        tick();
        check("vis_state", int'(current_state), 6);
        run = 1'b0;

        // Reset clears the sticky error; then exercise the watchdog at S3.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("err_cleared", int'(cfg_err), 0);
        program_table();
        run = 1'b1; x = 1'b1;
        tick();
        x = 1'b0;
        tick();
        check("wd_at_s3", int'(current_state), 3);
        for (int k = 1; k <= STK; k++) begin
            tick();
            check("wd_stuck", int'(stuck), int'(STUCK_EN && k >= STK));
        end
        x = 1'b1; #1;
        check("wd_still_stuck", int'(stuck), int'(STUCK_EN));
        tick();
        check("wd_moved", int'(current_state), 2);
        check("wd_cleared", int'(stuck), 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            run       = $urandom_range(0, 1);
            x         = XW'($urandom_range(0, 1));
            cfg_valid = $urandom_range(0, 1);
            cfg_sel   = $urandom_range(0, 1);
            cfg_x     = XW'($urandom_range(0, 1));
            cfg_state = ($urandom_range(0, 9) == 0) ? SW'($urandom_range(12, 15))
                                                    : SW'($urandom_range(0, 11));
            cfg_data  = ($urandom_range(0, 9) == 0) ? DW'($urandom_range(12, 15))
                                                    : DW'($urandom_range(0, 11));
            tick();
        end

        reset = 1'b1; run = 1'b0; cfg_valid = 1'b0;
        tick();
        check("final_err_clear", int'(cfg_err), 0);
        check("final_state", int'(current_state), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
